// File: rtl/branch_predictor.sv
// Dynamic branch predictor for the fetch stage: direct-mapped BTB with per-entry
// saturating counters, trained from EX, plus branch/mispredict statistics.
module branch_predictor #(
    parameter int PC_W    = 16,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_pc,
    input  logic              upd_valid,
    input  logic              upd_is_branch,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [PC_W-1:0]   upd_pred_pc,
    output logic              mispredict,
    input  logic              bp_clear,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [CNT_W-1:0]  CNT_WEAK_NT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0]  CNT_WEAK_T  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam logic [STAT_W-1:0] STAT_MAX    = '1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    entry_t ents [ENTRIES];

    // Lookup side: purely combinational from registered table state.
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [PC_W-1:0]  lk_pc_inc;
    entry_t           lk_ent;

    assign lk_idx    = pc[IDX_W:1];
    assign lk_tag    = pc[IDX_W+TAG_W:IDX_W+1];
    assign lk_ent    = ents[lk_idx];
    assign lk_hit    = lk_ent.valid && (lk_ent.tag == lk_tag);
    assign lk_pc_inc = pc + PC_W'(2);

    assign pred_taken = lk_hit && lk_ent.cnt[CNT_W-1];
    assign pred_pc    = pred_taken ? lk_ent.target : lk_pc_inc;

    // Update side: resolution from EX.
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [PC_W-1:0]  up_actual_pc;
    entry_t           up_ent;
    logic [CNT_W-1:0] cnt_next;
    logic             is_branch_upd;
    logic             do_train;
    logic             do_alloc;
    logic             do_inval;

    assign up_idx       = upd_pc[IDX_W:1];
    assign up_tag       = upd_pc[IDX_W+TAG_W:IDX_W+1];
    assign up_ent       = ents[up_idx];
    assign up_hit       = up_ent.valid && (up_ent.tag == up_tag);
    assign up_actual_pc = upd_taken ? upd_target : upd_pc + PC_W'(2);

    assign is_branch_upd = upd_valid && upd_is_branch;
    assign mispredict    = is_branch_upd && (upd_pred_pc != up_actual_pc);

    assign do_train = is_branch_upd && up_hit;
    assign do_alloc = is_branch_upd && !up_hit && upd_taken;
    assign do_inval = upd_valid && !upd_is_branch && up_hit;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_next = up_ent.cnt;
        if (upd_taken) begin
            if (up_ent.cnt != CNT_MAX) cnt_next = up_ent.cnt + 1'b1;
        end else begin
            if (up_ent.cnt != '0) cnt_next = up_ent.cnt - 1'b1;
        end
    end

    // One register bank per entry; a shared write decode picks the indexed one.
    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        entry_t ent_q;
        logic   sel;

        assign sel     = (up_idx == IDX_W'(g));
        assign ents[g] = ent_q;

        // NOTE: the table itself is reset (not just the valid bits) because the
        // counters must come up weakly not-taken and targets must read as zero.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ent_q.valid  <= 1'b0;
                ent_q.tag    <= '0;
                ent_q.target <= '0;
                ent_q.cnt    <= CNT_WEAK_NT;
            end else if (bp_clear) begin
                ent_q.valid <= 1'b0;
                ent_q.cnt   <= CNT_WEAK_NT;
            end else if (sel) begin
                if (do_alloc) begin
                    ent_q.valid  <= 1'b1;
                    ent_q.tag    <= up_tag;
                    ent_q.target <= upd_target;
                    ent_q.cnt    <= CNT_WEAK_T;
                end else if (do_train) begin
                    ent_q.cnt <= cnt_next;
                    if (upd_taken) ent_q.target <= upd_target;
                end else if (do_inval) begin
                    ent_q.valid <= 1'b0;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (is_branch_upd && stat_branches != STAT_MAX)
                stat_branches <= stat_branches + 1'b1;
            if (mispredict && stat_mispredicts != STAT_MAX)
                stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end

    // Only the index/tag slices of the PCs matter; the fetch-time direction
    // is implied by upd_pred_pc.
    logic unused_bits;
    assign unused_bits = ^{pc, upd_pc, upd_pred_taken};

endmodule
